// File: rtl/l2_trace_dispatcher.sv
// Trace-entry FIFO and op dispatcher sitting in front of the L2 cache.
// Issues one decoded cache operation at a time and keeps local-access statistics.
module l2_trace_dispatcher #(
  parameter int unsigned ADDR_BITS   = 32,
  parameter int unsigned BYTE_SELECT = 6,
  parameter int unsigned INDEX_BITS  = 14,
  parameter int unsigned TAG_BITS    = 12,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned CNT_W       = 32
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   trace_valid,
  output logic                   trace_ready,
  input  logic [3:0]             trace_cmd,
  input  logic [ADDR_BITS-1:0]   trace_addr,
  output logic                   op_valid,
  input  logic                   op_ready,
  output logic [7:0]             op_code,
  output logic                   op_snoop,
  output logic [TAG_BITS-1:0]    op_tag,
  output logic [INDEX_BITS-1:0]  op_index,
  output logic [BYTE_SELECT-1:0] op_offset,
  input  logic                   op_done,
  input  logic                   op_hit,
  output logic                   cache_clear,
  output logic                   stats_print,
  output logic                   busy,
  output logic [CNT_W-1:0]       read_cnt,
  output logic [CNT_W-1:0]       write_cnt,
  output logic [CNT_W-1:0]       hit_cnt,
  output logic [CNT_W-1:0]       miss_cnt,
  output logic [CNT_W-1:0]       err_cnt
);

  localparam int unsigned PtrW   = $clog2(FIFO_DEPTH);
  localparam int unsigned EntryW = 4 + ADDR_BITS;

  localparam logic [7:0]      CodeRead   = 8'h52;
  localparam logic [7:0]      CodeWrite  = 8'h57;
  localparam logic [7:0]      CodeModify = 8'h4D;
  localparam logic [7:0]      CodeInval  = 8'h49;
  localparam logic [PtrW:0]   PtrOne     = (PtrW + 1)'(1);
  localparam logic [CNT_W-1:0] CntOne    = CNT_W'(1);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StClear} state_e;

  state_e state_q, state_d;

  // FIFO storage and pointers (extra MSB distinguishes full from empty)
  logic [EntryW-1:0] fifo_mem [FIFO_DEPTH];
  logic [PtrW:0]     wr_ptr_q, rd_ptr_q;
  logic              fifo_full, fifo_empty, push, pop;

  logic [3:0]           head_cmd;
  logic [ADDR_BITS-1:0] head_addr;
  logic                 head_is_op, head_is_clear, head_is_print, head_illegal;
  logic                 head_snoop, head_read, head_write, head_local;
  logic [7:0]           head_code;

  logic [7:0]             op_code_q;
  logic                   op_snoop_q;
  logic [TAG_BITS-1:0]    op_tag_q;
  logic [INDEX_BITS-1:0]  op_index_q;
  logic [BYTE_SELECT-1:0] op_offset_q;
  logic                   op_local_q, op_read_q, op_write_q;

  logic [CNT_W-1:0] read_cnt_q, write_cnt_q, hit_cnt_q, miss_cnt_q, err_cnt_q;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CntOne;
  endfunction

  assign fifo_empty  = (wr_ptr_q == rd_ptr_q);
  assign fifo_full   = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
                       (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);
  assign trace_ready = !fifo_full;
  assign push        = trace_valid && trace_ready;
  assign pop         = (state_q == StIdle) && !fifo_empty;

  assign {head_cmd, head_addr} = fifo_mem[rd_ptr_q[PtrW-1:0]];

  always_ff @(posedge clock) begin
    if (push) begin
      fifo_mem[wr_ptr_q[PtrW-1:0]] <= {trace_cmd, trace_addr};
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrOne;
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrOne;
    end
  end

  always_comb begin
    head_is_op    = 1'b0;
    head_is_clear = 1'b0;
    head_is_print = 1'b0;
    head_snoop    = 1'b0;
    head_read     = 1'b0;
    head_write    = 1'b0;
    head_code     = 8'h00;
    case (head_cmd)
      4'd0, 4'd2: begin head_is_op = 1'b1; head_code = CodeRead;  head_read  = 1'b1; end
      4'd1:       begin head_is_op = 1'b1; head_code = CodeWrite; head_write = 1'b1; end
      4'd3:       begin head_is_op = 1'b1; head_code = CodeInval;  head_snoop = 1'b1; end
      4'd4:       begin head_is_op = 1'b1; head_code = CodeRead;   head_snoop = 1'b1; end
      4'd5:       begin head_is_op = 1'b1; head_code = CodeWrite;  head_snoop = 1'b1; end
      4'd6:       begin head_is_op = 1'b1; head_code = CodeModify; head_snoop = 1'b1; end
      4'd8:       head_is_clear = 1'b1;
      4'd9:       head_is_print = 1'b1;
      default:    ;
    endcase
  end

  assign head_illegal = !(head_is_op || head_is_clear || head_is_print);
  assign head_local   = head_is_op && !head_snoop;

  // FSM: state register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= StIdle;
    else          state_q <= state_d;
  end

  // FSM: next state; op_done outside WAIT/CLEAR is deliberately ignored
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (pop && head_is_op)         state_d = StIssue;
        else if (pop && head_is_clear) state_d = StClear;
      end
      StIssue: if (op_ready) state_d = StWait;
      StWait:  if (op_done)  state_d = StIdle;
      StClear: if (op_done)  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM: outputs
  always_comb begin
    op_valid    = (state_q == StIssue);
    cache_clear = (state_q == StClear);
    stats_print = pop && head_is_print;
    busy        = (state_q != StIdle) || !fifo_empty;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      op_code_q   <= '0;
      op_snoop_q  <= 1'b0;
      op_tag_q    <= '0;
      op_index_q  <= '0;
      op_offset_q <= '0;
      op_local_q  <= 1'b0;
      op_read_q   <= 1'b0;
      op_write_q  <= 1'b0;
    end else if (pop && head_is_op) begin
      op_code_q   <= head_code;
      op_snoop_q  <= head_snoop;
      op_tag_q    <= head_addr[ADDR_BITS-1 -: TAG_BITS];
      op_index_q  <= head_addr[BYTE_SELECT +: INDEX_BITS];
      op_offset_q <= head_addr[BYTE_SELECT-1:0];
      op_local_q  <= head_local;
      op_read_q   <= head_read;
      op_write_q  <= head_write;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      read_cnt_q  <= '0;
      write_cnt_q <= '0;
      hit_cnt_q   <= '0;
      miss_cnt_q  <= '0;
      err_cnt_q   <= '0;
    end else begin
      if (state_q == StWait && op_done && op_local_q) begin
        if (op_read_q)  read_cnt_q  <= sat_inc(read_cnt_q);
        if (op_write_q) write_cnt_q <= sat_inc(write_cnt_q);
        if (op_hit)     hit_cnt_q   <= sat_inc(hit_cnt_q);
        else            miss_cnt_q  <= sat_inc(miss_cnt_q);
      end else if (state_q == StClear && op_done) begin
        read_cnt_q  <= '0;
        write_cnt_q <= '0;
        hit_cnt_q   <= '0;
        miss_cnt_q  <= '0;
      end
      if (pop && head_illegal) err_cnt_q <= sat_inc(err_cnt_q);
    end
  end

  assign op_code   = op_code_q;
  assign op_snoop  = op_snoop_q;
  assign op_tag    = op_tag_q;
  assign op_index  = op_index_q;
  assign op_offset = op_offset_q;
  assign read_cnt  = read_cnt_q;
  assign write_cnt = write_cnt_q;
  assign hit_cnt   = hit_cnt_q;
  assign miss_cnt  = miss_cnt_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_l2_trace_dispatcher.sv
// Randomized self-checking bench for l2_trace_dispatcher with a queue/counter reference model.
module tb_l2_trace_dispatcher;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        trace_valid, trace_ready;
  logic [3:0]  trace_cmd;
  logic [31:0] trace_addr;
  logic        op_valid, op_ready;
  logic [7:0]  op_code;
  logic        op_snoop;
  logic [11:0] op_tag;
  logic [13:0] op_index;
  logic [5:0]  op_offset;
  logic        op_done, op_hit, cache_clear, stats_print, busy;
  logic [31:0] read_cnt, write_cnt, hit_cnt, miss_cnt, err_cnt;

  l2_trace_dispatcher dut (
    .clock(clock), .reset_n(reset_n),
    .trace_valid(trace_valid), .trace_ready(trace_ready),
    .trace_cmd(trace_cmd), .trace_addr(trace_addr),
    .op_valid(op_valid), .op_ready(op_ready), .op_code(op_code), .op_snoop(op_snoop),
    .op_tag(op_tag), .op_index(op_index), .op_offset(op_offset),
    .op_done(op_done), .op_hit(op_hit), .cache_clear(cache_clear),
    .stats_print(stats_print), .busy(busy),
    .read_cnt(read_cnt), .write_cnt(write_cnt), .hit_cnt(hit_cnt),
    .miss_cnt(miss_cnt), .err_cnt(err_cnt)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad = 0;
  int m_read, m_write, m_hit, m_miss, m_err;

  logic [40:0]  act_op;
  logic [159:0] act_cnts;
  assign act_op   = {op_code, op_snoop, op_tag, op_index, op_offset};
  assign act_cnts = {read_cnt, write_cnt, hit_cnt, miss_cnt, err_cnt};

  // Reference model: command classes, expected op fields, statistics
  function automatic int cmd_kind(input logic [3:0] c);
    case (c)
      4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6: return 0;
      4'd8:    return 1;
      4'd9:    return 2;
      default: return 3;
    endcase
  endfunction

  function automatic logic [7:0] exp_code(input logic [3:0] c);
    case (c)
      4'd0, 4'd2, 4'd4: return "R";
      4'd1, 4'd5:       return "W";
      4'd3:             return "I";
      4'd6:             return "M";
      default:          return 8'h00;
    endcase
  endfunction

  function automatic logic [40:0] exp_op(input logic [3:0] c, input logic [31:0] a);
    logic snoop;
    snoop = (c >= 4'd3) && (c <= 4'd6);
    return {exp_code(c), snoop, 12'(a / 32'h100000), 14'((a / 64) % 16384), 6'(a % 64)};
  endfunction

  function automatic logic [159:0] exp_cnts();
    return {32'(m_read), 32'(m_write), 32'(m_hit), 32'(m_miss), 32'(m_err)};
  endfunction

  task automatic model_complete(input logic [3:0] c, input bit hit);
    if (c == 4'd0 || c == 4'd2) m_read++;
    if (c == 4'd1) m_write++;
    if (c <= 4'd2) begin
      if (hit) m_hit++;
      else     m_miss++;
    end
  endtask

  task automatic model_clear();
    m_read = 0; m_write = 0; m_hit = 0; m_miss = 0;
  endtask

  // Stimulus helpers (called at a falling edge, return at a falling edge)
  task automatic do_reset();
    reset_n = 1'b0; trace_valid = 1'b0; trace_cmd = '0; trace_addr = '0;
    op_ready = 1'b0; op_done = 1'b0; op_hit = 1'b0;
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    model_clear(); m_err = 0;
  endtask

  task automatic push(input logic [3:0] c, input logic [31:0] a, output bit ok);
    int i;
    i = 0;
    trace_cmd = c; trace_addr = a; trace_valid = 1'b1;
    while (!trace_ready && i < 50) begin
      @(negedge clock);
      i++;
    end
    ok = trace_ready;
    @(negedge clock);
    trace_valid = 1'b0;
  endtask

  task automatic serve(input bit hit, input int rdly, input int ddly,
                       output bit ok, output logic [40:0] f);
    int i;
    i = 0;
    while (!op_valid && i < 50) begin
      @(negedge clock);
      i++;
    end
    ok = op_valid;
    f  = act_op;
    if (!ok) return;
    repeat (rdly) @(negedge clock);
    op_ready = 1'b1;
    @(negedge clock);
    op_ready = 1'b0;
    repeat (ddly) @(negedge clock);
    op_done = 1'b1; op_hit = hit;
    @(negedge clock);
    op_done = 1'b0; op_hit = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if ({trace_ready, op_valid, cache_clear, stats_print, busy} !== 5'b10000) begin
      bad++;
      $display("FAIL reset_ctrl got=%b exp=10000",
               {trace_ready, op_valid, cache_clear, stats_print, busy});
    end
    total++;
    if (act_cnts !== exp_cnts()) begin
      bad++; $display("FAIL reset_cnts got=%h exp=%h", act_cnts, exp_cnts());
    end
    total++;
    if (act_op !== 41'h0) begin
      bad++; $display("FAIL reset_op got=%h exp=0", act_op);
    end
  endtask

  task automatic test_basic();
    bit ok;
    logic [40:0] f;
    logic [31:0] a;
    a = 32'h1234_5678;
    push(4'd0, a, ok);
    total++;
    if (!ok || op_valid !== 1'b0) begin
      bad++; $display("FAIL t1_early ok=%0d op_valid=%b exp=0", ok, op_valid);
    end
    @(negedge clock);
    total++;
    if (op_valid !== 1'b1) begin
      bad++; $display("FAIL t1_latency op_valid=%b exp=1", op_valid);
    end
    serve(1'b0, 0, 1, ok, f);
    total++;
    if (!ok || f !== exp_op(4'd0, a)) begin
      bad++; $display("FAIL t1_fields ok=%0d got=%h exp=%h", ok, f, exp_op(4'd0, a));
    end
    model_complete(4'd0, 1'b0);
    total++;
    if (act_cnts !== exp_cnts()) begin
      bad++; $display("FAIL t1_cnts got=%h exp=%h", act_cnts, exp_cnts());
    end
  endtask

  task automatic test_burst();
    logic [3:0]  pc[$], ec[$];
    logic [31:0] pa[$], ea[$];
    bit          hq[$], okq[$];
    logic [40:0] gotq[$];
    logic [3:0]  choices[4];
    logic [40:0] f_b;
    bit          ok_b;
    int          accepted;
    choices = '{4'd0, 4'd1, 4'd4, 4'd5};
    for (int i = 0; i < 6; i++) begin
      pc.push_back(choices[$urandom_range(0, 3)]);
      pa.push_back($urandom);
      hq.push_back(1'($urandom_range(0, 1)));
    end
    ec = pc; ea = pa;
    op_ready = 1'b0;
    accepted = 0;
    for (int i = 0; i < 10; i++) begin
      trace_valid = 1'b1; trace_cmd = pc[0]; trace_addr = pa[0];
      if (trace_ready) begin
        pc.delete(0); pa.delete(0); accepted++;
      end
      @(negedge clock);
    end
    total++;
    if (accepted !== 5 || trace_ready !== 1'b0) begin
      bad++; $display("FAIL t2_backpressure accepted=%0d ready=%b exp=5/0", accepted, trace_ready);
    end
    total++;
    if (op_valid !== 1'b1 || act_op !== exp_op(ec[0], ea[0])) begin
      bad++; $display("FAIL t2_hold valid=%b got=%h exp=%h", op_valid, act_op, exp_op(ec[0], ea[0]));
    end
    fork
      begin
        for (int g = 0; g < 200 && pc.size() > 0; g++) begin
          trace_valid = 1'b1; trace_cmd = pc[0]; trace_addr = pa[0];
          if (trace_ready) begin
            pc.delete(0); pa.delete(0);
          end
          @(negedge clock);
        end
        trace_valid = 1'b0;
      end
      begin
        for (int i = 0; i < 6; i++) begin
          serve(hq[i], $urandom_range(0, 2), $urandom_range(0, 3), ok_b, f_b);
          okq.push_back(ok_b); gotq.push_back(f_b);
        end
      end
    join
    for (int i = 0; i < 6; i++) begin
      total++;
      if (!okq[i] || gotq[i] !== exp_op(ec[i], ea[i])) begin
        bad++;
        $display("FAIL t2_order_%0d ok=%0d got=%h exp=%h", i, okq[i], gotq[i], exp_op(ec[i], ea[i]));
      end
      model_complete(ec[i], hq[i]);
    end
    total++;
    if (act_cnts !== exp_cnts()) begin
      bad++; $display("FAIL t2_cnts got=%h exp=%h", act_cnts, exp_cnts());
    end
  endtask

  task automatic test_snoop();
    bit ok;
    logic [40:0] f;
    logic [31:0] a;
    logic [3:0]  cmds[2];
    cmds = '{4'd6, 4'd3};
    for (int i = 0; i < 2; i++) begin
      a = $urandom;
      push(cmds[i], a, ok);
      serve(1'b1, $urandom_range(0, 2), $urandom_range(0, 2), ok, f);
      total++;
      if (!ok || f !== exp_op(cmds[i], a)) begin
        bad++; $display("FAIL t3_snoop_%0d got=%h exp=%h", i, f, exp_op(cmds[i], a));
      end
      model_complete(cmds[i], 1'b1);
    end
    total++;
    if (act_cnts !== exp_cnts()) begin
      bad++; $display("FAIL t3_cnts got=%h exp=%h", act_cnts, exp_cnts());
    end
  endtask

  task automatic test_clear_print();
    bit ok;
    logic [40:0] f;
    int held, n;
    for (int i = 0; i < 2; i++) begin
      push(4'd1, $urandom, ok);
      serve(1'b1, 0, $urandom_range(0, 2), ok, f);
      model_complete(4'd1, 1'b1);
    end
    total++;
    if (act_cnts !== exp_cnts()) begin
      bad++; $display("FAIL t4_pre_cnts got=%h exp=%h", act_cnts, exp_cnts());
    end
    push(4'd8, $urandom, ok);
    @(negedge clock);
    held = 1;
    repeat (3) begin
      if (!cache_clear || op_valid) held = 0;
      @(negedge clock);
    end
    total++;
    if (held != 1) begin
      bad++; $display("FAIL t4_clear_hold cache_clear=%b op_valid=%b exp=1/0", cache_clear, op_valid);
    end
    op_done = 1'b1;
    @(negedge clock);
    op_done = 1'b0;
    model_clear();
    total++;
    if (cache_clear !== 1'b0 || act_cnts !== exp_cnts()) begin
      bad++; $display("FAIL t4_cleared clr=%b got=%h exp=%h", cache_clear, act_cnts, exp_cnts());
    end
    push(4'd9, $urandom, ok);
    n = 0;
    for (int i = 0; i < 5; i++) begin
      if (stats_print) n++;
      if (op_valid) n += 100;
      @(negedge clock);
    end
    total++;
    if (n != 1) begin
      bad++; $display("FAIL t4_print pulses=%0d exp=1", n);
    end
  endtask

  task automatic test_illegal();
    bit ok;
    bit hit;
    logic [40:0] f;
    logic [31:0] a;
    push(4'd7, $urandom, ok);
    push(4'd15, $urandom, ok);
    a = $urandom;
    push(4'd2, a, ok);
    m_err += 2;
    total++;
    if (op_valid !== 1'b0 || act_cnts !== exp_cnts()) begin
      bad++; $display("FAIL t5_err valid=%b got=%h exp=%h", op_valid, act_cnts, exp_cnts());
    end
    hit = 1'($urandom_range(0, 1));
    serve(hit, 1, 1, ok, f);
    total++;
    if (!ok || f !== exp_op(4'd2, a)) begin
      bad++; $display("FAIL t5_after got=%h exp=%h", f, exp_op(4'd2, a));
    end
    model_complete(4'd2, hit);
    total++;
    if (act_cnts !== exp_cnts()) begin
      bad++; $display("FAIL t5_cnts got=%h exp=%h", act_cnts, exp_cnts());
    end
  endtask

  task automatic test_done_ignored();
    bit ok;
    push(4'd0, $urandom, ok);
    @(negedge clock);
    total++;
    if (op_valid !== 1'b1) begin
      bad++; $display("FAIL ign_issue op_valid=%b exp=1", op_valid);
    end
    op_done = 1'b1; op_hit = 1'b1;
    @(negedge clock);
    op_ready = 1'b1;
    @(negedge clock);
    op_ready = 1'b0; op_done = 1'b0; op_hit = 1'b0;
    total++;
    if (op_valid !== 1'b0 || busy !== 1'b1 || act_cnts !== exp_cnts()) begin
      bad++;
      $display("FAIL ign_done valid=%b busy=%b got=%h exp=%h", op_valid, busy, act_cnts, exp_cnts());
    end
    op_done = 1'b1;
    @(negedge clock);
    op_done = 1'b0;
    model_complete(4'd0, 1'b0);
    total++;
    if (busy !== 1'b0 || act_cnts !== exp_cnts()) begin
      bad++; $display("FAIL ign_final busy=%b got=%h exp=%h", busy, act_cnts, exp_cnts());
    end
  endtask

  task automatic test_random();
    bit ok, hit;
    logic [40:0] f;
    logic [31:0] a;
    logic [3:0]  c;
    int n, w;
    for (int it = 0; it < 40; it++) begin
      c = 4'($urandom_range(0, 15));
      a = $urandom;
      hit = 1'($urandom_range(0, 1));
      push(c, a, ok);
      case (cmd_kind(c))
        0: begin
          serve(hit, $urandom_range(0, 3), $urandom_range(0, 3), ok, f);
          total++;
          if (!ok || f !== exp_op(c, a)) begin
            bad++; $display("FAIL rnd_op_%0d cmd=%0d got=%h exp=%h", it, c, f, exp_op(c, a));
          end
          model_complete(c, hit);
        end
        1: begin
          w = 0;
          while (!cache_clear && w < 20) begin
            @(negedge clock);
            w++;
          end
          total++;
          if (cache_clear !== 1'b1) begin
            bad++; $display("FAIL rnd_clear_%0d cache_clear=%b exp=1", it, cache_clear);
          end
          repeat ($urandom_range(0, 3)) @(negedge clock);
          op_done = 1'b1;
          @(negedge clock);
          op_done = 1'b0;
          model_clear();
        end
        2: begin
          n = 0;
          for (int i = 0; i < 3; i++) begin
            if (stats_print) n++;
            @(negedge clock);
          end
          total++;
          if (n != 1) begin
            bad++; $display("FAIL rnd_print_%0d pulses=%0d exp=1", it, n);
          end
        end
        default: begin
          m_err++;
          @(negedge clock);
        end
      endcase
      total++;
      if ({busy, act_cnts} !== {1'b0, exp_cnts()}) begin
        bad++;
        $display("FAIL rnd_cnts_%0d busy=%b got=%h exp=%h", it, busy, act_cnts, exp_cnts());
      end
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int seen;
    push(4'd0, $urandom, ok);
    @(negedge clock);
    op_ready = 1'b1;
    @(negedge clock);
    op_ready = 1'b0;
    push(4'd1, $urandom, ok);
    #2 reset_n = 1'b0;
    #1;
    model_clear(); m_err = 0;
    total++;
    if ({op_valid, cache_clear, stats_print, busy} !== 4'b0000 || act_cnts !== exp_cnts()) begin
      bad++;
      $display("FAIL t6_async ctrl=%b got=%h exp=0", {op_valid, cache_clear, stats_print, busy},
               act_cnts);
    end
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    total++;
    if (trace_ready !== 1'b1 || busy !== 1'b0) begin
      bad++; $display("FAIL t6_release ready=%b busy=%b exp=1/0", trace_ready, busy);
    end
    seen = 0;
    repeat (4) begin
      if (op_valid || busy) seen++;
      @(negedge clock);
    end
    total++;
    if (seen != 0) begin
      bad++; $display("FAIL t6_quiet active_cycles=%0d exp=0", seen);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_burst();
    test_snoop();
    test_clear_print();
    test_illegal();
    test_done_ignored();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
